// File: rtl/wavegen_cmd_ctrl_pkg.sv
// Shared constants for the waveform-generator command controller:
// opcodes, response bytes, read indices, FSM encoding and reset values.
package wavegen_cmd_pkg;

    localparam logic [7:0] OP_W = 8'h57;
    localparam logic [7:0] OP_F = 8'h46;
    localparam logic [7:0] OP_A = 8'h41;
    localparam logic [7:0] OP_E = 8'h45;
    localparam logic [7:0] OP_R = 8'h52;

    localparam logic [7:0] ACK = 8'h4B;
    localparam logic [7:0] NAK = 8'h3F;
    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] LF  = 8'h0A;

    localparam logic [7:0] RIDX_WAVE = 8'd0;
    localparam logic [7:0] RIDX_STEP = 8'd1;
    localparam logic [7:0] RIDX_AMP  = 8'd2;
    localparam logic [7:0] RIDX_EN   = 8'd3;
    localparam logic [7:0] RIDX_VER  = 8'd4;

    localparam logic [7:0] WAVE_MAX = 8'd3;
    localparam logic [7:0] RIDX_MAX = 8'd4;

    localparam logic [1:0] RST_WAVE_SEL  = 2'd0;
    localparam logic [7:0] RST_AMPLITUDE = 8'hFF;
    localparam logic       RST_GEN_EN    = 1'b1;
    localparam logic [7:0] DEF_PHASE_STEP = 8'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARG,
        ST_EXEC,
        ST_RESP
    } state_t;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_W) || (b == OP_F) || (b == OP_A) || (b == OP_E) || (b == OP_R);
    endfunction

endpackage

// File: rtl/wavegen_cmd_ctrl_if.sv
// Byte stream link to avr_interface: RX strobe/data in, TX strobe/data out with busy.
interface wavegen_cmd_ctrl_if;
    logic [7:0] rx_data;
    logic       new_rx_data;
    logic [7:0] tx_data;
    logic       new_tx_data;
    logic       tx_busy;

    modport master (
        output rx_data, new_rx_data, tx_busy,
        input  tx_data, new_tx_data
    );

    modport slave (
        input  rx_data, new_rx_data, tx_busy,
        output tx_data, new_tx_data
    );
endinterface

// File: rtl/wavegen_cmd_ctrl_timeout.sv
// Inter-byte timeout counter: cleared on opcode, counts while enabled and
// flags the terminal cycle (TIMEOUT_CYCLES-1); holds at terminal count.
module cmd_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != TC_VAL)) begin
            count <= count + CW'(1);
        end
    end

    assign tc = enable && (count == TC_VAL);

endmodule

// File: rtl/wavegen_cmd_ctrl.sv
// Two-byte command parser (opcode, argument) that updates the waveform
// generator configuration and returns one response byte per command.
module wavegen_cmd_ctrl
    import wavegen_cmd_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 5000000,
    parameter logic [7:0] RESET_STEP     = DEF_PHASE_STEP,
    parameter logic [7:0] VERSION        = 8'h01
) (
    input  logic                clk,
    input  logic                rst_n,
    wavegen_cmd_ctrl_if.slave   bus,
    output logic [1:0]          wave_sel,
    output logic [7:0]          phase_step,
    output logic [7:0]          amplitude,
    output logic                gen_en,
    output logic                cfg_update
);

    state_t     state, state_n;
    logic [7:0] opcode;
    logic [7:0] arg;
    logic       to_clear;
    logic       to_tc;
    logic       exec_ok;
    logic       exec_wr;
    logic [7:0] exec_resp;
    logic [7:0] rd_val;
    logic       rx_is_op;
    logic       rx_is_eol;

    assign rx_is_op  = is_opcode(bus.rx_data);
    assign rx_is_eol = (bus.rx_data == CR) || (bus.rx_data == LF);

    cmd_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (to_clear),
        .enable (state == ST_ARG),
        .tc     (to_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n         = state;
        to_clear        = 1'b0;
        bus.new_tx_data = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.new_rx_data) begin
                    if (rx_is_op) begin
                        state_n  = ST_ARG;
                        to_clear = 1'b1;
                    end else if (!rx_is_eol) begin
                        state_n = ST_RESP;
                    end
                end
            end
            // An argument on the terminal-count cycle takes priority over the timeout.
            ST_ARG: begin
                if (bus.new_rx_data) begin
                    state_n = ST_EXEC;
                end else if (to_tc) begin
                    state_n = ST_RESP;
                end
            end
            ST_EXEC: state_n = ST_RESP;
            ST_RESP: begin
                if (!bus.tx_busy) begin
                    bus.new_tx_data = 1'b1;
                    state_n         = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_val = VERSION;
        case (arg)
            RIDX_WAVE: rd_val = {6'b0, wave_sel};
            RIDX_STEP: rd_val = phase_step;
            RIDX_AMP:  rd_val = amplitude;
            RIDX_EN:   rd_val = {7'b0, gen_en};
            default:   rd_val = VERSION;
        endcase
    end

    always_comb begin
        exec_ok = 1'b0;
        exec_wr = 1'b0;
        case (opcode)
            OP_W: begin exec_ok = (arg <= WAVE_MAX); exec_wr = exec_ok; end
            OP_F: begin exec_ok = (arg != 8'd0);     exec_wr = exec_ok; end
            OP_A: begin exec_ok = 1'b1;              exec_wr = 1'b1;    end
            OP_E: begin exec_ok = 1'b1;              exec_wr = 1'b1;    end
            OP_R: begin exec_ok = (arg <= RIDX_MAX); exec_wr = 1'b0;    end
            default: begin exec_ok = 1'b0; exec_wr = 1'b0; end
        endcase
        if (!exec_ok) begin
            exec_resp = NAK;
        end else if (opcode == OP_R) begin
            exec_resp = rd_val;
        end else begin
            exec_resp = ACK;
        end
    end

    // Opcode/argument holding registers carry data only and need no reset.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && bus.new_rx_data && rx_is_op) begin
            opcode <= bus.rx_data;
        end
        if (state == ST_ARG && bus.new_rx_data) begin
            arg <= bus.rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wave_sel    <= RST_WAVE_SEL;
            phase_step  <= RESET_STEP;
            amplitude   <= RST_AMPLITUDE;
            gen_en      <= RST_GEN_EN;
            cfg_update  <= 1'b0;
            bus.tx_data <= 8'h00;
        end else begin
            cfg_update <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.new_rx_data && !rx_is_op && !rx_is_eol) begin
                        bus.tx_data <= NAK;
                    end
                end
                ST_ARG: begin
                    if (!bus.new_rx_data && to_tc) begin
                        bus.tx_data <= NAK;
                    end
                end
                ST_EXEC: begin
                    bus.tx_data <= exec_resp;
                    if (exec_wr) begin
                        cfg_update <= 1'b1;
                        case (opcode)
                            OP_W:    wave_sel   <= arg[1:0];
                            OP_F:    phase_step <= arg;
                            OP_A:    amplitude  <= arg;
                            OP_E:    gen_en     <= arg[0];
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wavegen_cmd_ctrl.sv
// Self-checking bench for wavegen_cmd_ctrl: table-driven commands plus
// hand-written timeout, busy-hold, CR/invalid and mid-command reset cases.
module tb_wavegen_cmd_ctrl;
    import wavegen_cmd_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wavegen_cmd_ctrl_if bus();
    logic [1:0] wave_sel;
    logic [7:0] phase_step;
    logic [7:0] amplitude;
    logic       gen_en;
    logic       cfg_update;

    wavegen_cmd_ctrl #(
        .TIMEOUT_CYCLES(100),
        .RESET_STEP    (8'd1),
        .VERSION       (8'h01)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .wave_sel   (wave_sel),
        .phase_step (phase_step),
        .amplitude  (amplitude),
        .gen_en     (gen_en),
        .cfg_update (cfg_update)
    );

    typedef struct {
        logic [7:0] resp;
        int         lo;
        int         hi;
    } exp_t;

    typedef struct {
        logic [7:0] op;
        logic [7:0] arg;
        logic [7:0] resp;
        logic [1:0] wave;
        logic [7:0] step;
        logic [7:0] amp;
        logic       en;
        int         cfg;
    } vec_t;

    exp_t sb[$];
    vec_t vt[14];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   cfg_cnt = 0;
    int   last_cfg_cyc = -1;
    int   last_tx_cyc = -1;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: every TX strobe must match the oldest expected byte and window.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (cfg_update) begin
                cfg_cnt++;
                last_cfg_cyc = cyc;
            end
            if (bus.new_tx_data) begin
                last_tx_cyc = cyc;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_tx actual=%0h required=no strobe (cycle %0d)", bus.tx_data, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("tx_data", int'(bus.tx_data), int'(e.resp));
                    n_cmp++;
                    if (cyc < e.lo || cyc > e.hi) begin
                        n_err++;
                        $display("FAIL tx_cycle actual=%0d required=%0d..%0d", cyc, e.lo, e.hi);
                    end
                end
            end
        end
    end

    task automatic drive_byte(input logic [7:0] b, output int c);
        @(posedge clk);
        #1;
        bus.rx_data = b;
        bus.new_rx_data = 1'b1;
        c = cyc;
        @(posedge clk);
        #1;
        bus.new_rx_data = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] r, input int lo, input int hi);
        exp_t e;
        e.resp = r;
        e.lo = lo;
        e.hi = hi;
        sb.push_back(e);
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] r, output int ac);
        int oc;
        drive_byte(op, oc);
        drive_byte(a, ac);
        push_exp(r, ac + 2, ac + 2);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s actual=%0d pending responses required=0", name, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ac;
        int oc;
        int cfg0;

        vt[0]  = '{8'h57, 8'h02, 8'h4B, 2'd2, 8'h01, 8'hFF, 1'b1, 1};
        vt[1]  = '{8'h46, 8'h00, 8'h3F, 2'd2, 8'h01, 8'hFF, 1'b1, 0};
        vt[2]  = '{8'h46, 8'h10, 8'h4B, 2'd2, 8'h10, 8'hFF, 1'b1, 1};
        vt[3]  = '{8'h41, 8'h80, 8'h4B, 2'd2, 8'h10, 8'h80, 1'b1, 1};
        vt[4]  = '{8'h52, 8'h02, 8'h80, 2'd2, 8'h10, 8'h80, 1'b1, 0};
        vt[5]  = '{8'h52, 8'h04, 8'h01, 2'd2, 8'h10, 8'h80, 1'b1, 0};
        vt[6]  = '{8'h52, 8'h05, 8'h3F, 2'd2, 8'h10, 8'h80, 1'b1, 0};
        vt[7]  = '{8'h57, 8'h04, 8'h3F, 2'd2, 8'h10, 8'h80, 1'b1, 0};
        vt[8]  = '{8'h57, 8'h02, 8'h4B, 2'd2, 8'h10, 8'h80, 1'b1, 1};
        vt[9]  = '{8'h52, 8'h00, 8'h02, 2'd2, 8'h10, 8'h80, 1'b1, 0};
        vt[10] = '{8'h45, 8'h00, 8'h4B, 2'd2, 8'h10, 8'h80, 1'b0, 1};
        vt[11] = '{8'h52, 8'h03, 8'h00, 2'd2, 8'h10, 8'h80, 1'b0, 0};
        vt[12] = '{8'h45, 8'h03, 8'h4B, 2'd2, 8'h10, 8'h80, 1'b1, 1};
        vt[13] = '{8'h52, 8'h01, 8'h10, 2'd2, 8'h10, 8'h80, 1'b1, 0};

        bus.rx_data = 8'h00;
        bus.new_rx_data = 1'b0;
        bus.tx_busy = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_wave_sel", int'(wave_sel), 0);
        chk("rst_phase_step", int'(phase_step), 1);
        chk("rst_amplitude", int'(amplitude), 8'hFF);
        chk("rst_gen_en", int'(gen_en), 1);
        chk("rst_cfg_update", int'(cfg_update), 0);
        chk("rst_new_tx_data", int'(bus.new_tx_data), 0);
        chk("rst_tx_data", int'(bus.tx_data), 0);

        for (int i = 0; i < 14; i++) begin
            cfg0 = cfg_cnt;
            send_cmd(vt[i].op, vt[i].arg, vt[i].resp, ac);
            wait_drain("vec_resp", 20);
            chk("vec_wave_sel", int'(wave_sel), int'(vt[i].wave));
            chk("vec_phase_step", int'(phase_step), int'(vt[i].step));
            chk("vec_amplitude", int'(amplitude), int'(vt[i].amp));
            chk("vec_gen_en", int'(gen_en), int'(vt[i].en));
            chk("vec_cfg_pulses", cfg_cnt - cfg0, vt[i].cfg);
            if (vt[i].cfg == 1) chk("vec_cfg_cycle", last_cfg_cyc, ac + 2);
        end

        // Opcode with no argument: NAK once the 100-cycle window expires.
        drive_byte(OP_A, oc);
        push_exp(NAK, oc + 100, oc + 101);
        wait_drain("timeout_resp", 150);
        chk("timeout_amplitude", int'(amplitude), 8'h80);
        send_cmd(OP_E, 8'h00, ACK, ac);
        wait_drain("after_timeout_resp", 20);
        chk("after_timeout_gen_en", int'(gen_en), 0);

        // Transmitter busy for 50 cycles; a stray 'A' during the wait is dropped.
        bus.tx_busy = 1'b1;
        drive_byte(OP_W, oc);
        drive_byte(8'h01, ac);
        push_exp(ACK, ac + 50, ac + 50);
        for (int i = 2; i <= 50; i++) begin
            @(posedge clk);
            #1;
            if (i == 10) begin
                bus.rx_data = OP_A;
                bus.new_rx_data = 1'b1;
            end
            if (i == 11) bus.new_rx_data = 1'b0;
            if (i == 50) bus.tx_busy = 1'b0;
        end
        wait_drain("busy_resp", 10);
        chk("busy_strobe_cycle", last_tx_cyc, ac + 50);
        chk("busy_wave_sel", int'(wave_sel), 1);
        repeat (5) @(posedge clk);
        send_cmd(OP_R, RIDX_AMP, 8'h80, ac);
        wait_drain("busy_idle_check", 20);

        // CR is silent, 'Z' gets an immediate NAK.
        drive_byte(CR, oc);
        repeat (5) @(posedge clk);
        drive_byte(8'h5A, oc);
        push_exp(NAK, oc + 1, oc + 1);
        wait_drain("bad_opcode_resp", 10);

        // Reset while waiting for an argument.
        drive_byte(OP_W, oc);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_wave_sel", int'(wave_sel), 0);
        chk("midrst_amplitude", int'(amplitude), 8'hFF);
        chk("midrst_gen_en", int'(gen_en), 1);
        chk("midrst_phase_step", int'(phase_step), 1);
        chk("midrst_new_tx_data", int'(bus.new_tx_data), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_cmd(OP_R, RIDX_WAVE, 8'h00, ac);
        wait_drain("post_rst_read", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
